// File: rtl/cycle_sequencer_pkg.sv
// ============================================================================
// cycle_sequencer_pkg : shared CPU phase codes, memory-opcode range, states
// Revision 1.0
// ============================================================================
`default_nettype none

package cycle_sequencer_pkg;

  localparam logic [2:0] PH_FETCH0 = 3'b100;
  localparam logic [2:0] PH_FETCH1 = 3'b000;
  localparam logic [2:0] PH_FETCH2 = 3'b001;
  localparam logic [2:0] PH_EXEC   = 3'b011;
  localparam logic [2:0] PH_MEM0   = 3'b101;
  localparam logic [2:0] PH_MEM1   = 3'b111;

  localparam logic [7:0] MEM_OP_LO = 8'h80;
  localparam logic [7:0] MEM_OP_HI = 8'h83;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM0   = 3'd5,
    ST_MEM1   = 3'd6
  } state_e;

  function automatic logic is_mem_op(input logic [7:0] op);
    return (op >= MEM_OP_LO) && (op <= MEM_OP_HI);
  endfunction

  // HALT shares the FETCH0 code so the decoder sees an idle fetch while parked.
  function automatic logic [2:0] phase_code(input state_e s);
    case (s)
      ST_FETCH1: return PH_FETCH1;
      ST_FETCH2: return PH_FETCH2;
      ST_EXEC:   return PH_EXEC;
      ST_MEM0:   return PH_MEM0;
      ST_MEM1:   return PH_MEM1;
      default:   return PH_FETCH0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cycle_sequencer.sv
// ============================================================================
// cycle_sequencer : instruction phase sequencer with run/step control
// Revision 1.0
// ============================================================================
`default_nettype none

module cycle_sequencer
  import cycle_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        mem_ready,
  input  logic        run,
  input  logic        step,
  output logic [2:0]  timer,
  output logic        halted,
  output logic        instr_done,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  logic [2:0]  timer_q, timer_d;
  logic        halted_q, halted_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        final_phase;
  logic        mem_op;
  logic        unused_low;

  assign mem_op     = is_mem_op(instruction[15:8]);
  assign unused_low = ^instruction[7:0];

  always_comb begin
    state_d     = state_q;
    final_phase = 1'b0;
    case (state_q)
      ST_HALT:   if (run || step) state_d = ST_FETCH0;
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: if (mem_ready) state_d = ST_FETCH2;
      ST_FETCH2: state_d = ST_EXEC;
      ST_EXEC: begin
        if (mem_op) begin
          state_d = ST_MEM0;
        end else begin
          final_phase = 1'b1;
          state_d     = run ? ST_FETCH0 : ST_HALT;
        end
      end
      ST_MEM0:   if (mem_ready) state_d = ST_MEM1;
      ST_MEM1: begin
        final_phase = 1'b1;
        state_d     = run ? ST_FETCH0 : ST_HALT;
      end
      default:   state_d = ST_HALT;
    endcase

    instr_count_d = final_phase ? instr_count_q + 16'd1 : instr_count_q;
    timer_d       = phase_code(state_d);
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HALT;
      timer_q       <= PH_FETCH0;
      halted_q      <= 1'b1;
      instr_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign timer       = timer_q;
  assign halted      = halted_q;
  assign instr_done  = final_phase && !reset;
  assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  Single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 instruction  input  16  Current instruction register contents; only bits [15:8] are decoded.
REQ-005 mem_ready  input  1  Memory handshake; high means the current memory access completes this cycle.
REQ-006 run  input  1  Level; high means free-running execution.
REQ-007 step  input  1  Single-cycle pulse; requests exactly one instruction while halted.
REQ-008 timer  output  3  Phase code driven to the control decoder.
REQ-009 halted  output  1  High while parked at an instruction boundary.
REQ-010 instr_done  output  1  One-cycle pulse on the final phase cycle of each retired instruction.
REQ-011 instr_count  output  16  Number of retired instructions.

Function
REQ-012 Phase codes SHALL be: FETCH0=3'b100, FETCH1=3'b000, FETCH2=3'b001, EXEC=3'b011, MEM0=3'b101, MEM1=3'b111.
REQ-013 timer SHALL equal the registered phase code, with no combinational path from any input to timer.
REQ-014 Normal order SHALL be FETCH0 -> FETCH1 -> FETCH2 -> EXEC, with each phase lasting one cycle unless stalled.
REQ-015 FETCH1 SHALL hold for as long as mem_ready=0, advancing on the first cycle with mem_ready=1.
REQ-016 MEM0 SHALL stall on mem_ready in the same way as FETCH1.
REQ-017 The other phases SHALL ignore mem_ready.
REQ-018 In EXEC, if instruction[15:8] is in 8'h80..8'h83, the next phases SHALL be MEM0 then MEM1; otherwise EXEC is the final phase.
REQ-019 The final phase SHALL be EXEC for non-memory instructions and MEM1 for memory instructions.
REQ-020 instr_done SHALL be 1 during the final phase cycle and 0 at all other times.
REQ-021 instr_count SHALL increment by 1 on each instr_done cycle, wrapping from 16'hFFFF to 16'h0000.
REQ-022 After the final phase, if run=1 the sequencer SHALL go to FETCH0; if run=0 it SHALL go to HALT.
REQ-023 In HALT, timer SHALL be 3'b100 and halted SHALL be 1.
REQ-024 From HALT, run=1 SHALL go to FETCH0 next cycle.
REQ-025 From HALT, a step pulse SHALL go to FETCH0 and execute one instruction, then return to HALT unless run=1 at its final phase.
REQ-026 When run and step are both high in HALT, the two SHALL behave identically to run=1 alone.
REQ-027 step SHALL be ignored outside HALT, including any step received mid-instruction.
REQ-028 Deasserting run mid-instruction SHALL never abort it; the instruction completes and the sequencer halts at the boundary.
REQ-029 The EXEC branch decision SHALL use the instruction value sampled during the EXEC cycle.

Reset
REQ-030 Reset SHALL force the state to HALT.
REQ-031 During reset, timer SHALL be 3'b100, halted=1, instr_done=0, and instr_count=16'h0000.
REQ-032 Reset SHALL take precedence over every other input in any phase, including a stalled FETCH1 or MEM0.
REQ-033 Reset SHALL not count a partially executed instruction.
REQ-034 The first phase after reset release with run=1 SHALL be FETCH0.

Structure
REQ-035 Phase codes, the memory-opcode range bounds (8'h80, 8'h83) and the state enumeration SHALL live in a shared CPU package, also used by the control decoder.
REQ-036 No sub-module SHALL be used; the state machine and counter SHALL form a single module.

Verification
REQ-037 Scenario: reset, then run=1, instruction=16'h0123, mem_ready=1 -> timer 100,000,001,011 repeating; instr_done every 4th cycle; instr_count=3 after 12 cycles.
REQ-038 Scenario: instruction=16'h8012, run=1, mem_ready=1 -> timer 100,000,001,011,101,111; instr_done only on 111.
REQ-039 Scenario: mem_ready=0 for 3 cycles on entering FETCH1 -> timer stays 000 for 4 cycles total, then goes to 001; same check for MEM0 with instruction=16'h8300.
REQ-040 Scenario: halted, run=0, single step pulse -> exactly one instruction runs, instr_count +1, halted=1 again; a second step during EXEC is ignored.
REQ-041 Scenario: run drops during FETCH2 -> the instruction completes and the sequencer halts; reset asserted during a stalled MEM0 -> next cycle timer=100, halted=1, instr_count=0.
REQ-042 Scenario: instr_count preloaded near wrap by running 65535 instructions -> the next instr_done gives instr_count=16'h0000.
